pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Drives the i_we (stall) and i_s_rst (flush/bubble) controls of the IF/ID and ID/EX pipeline registers and the PC write enable.
//  Detects load-use and RAW hazards, squashes wrong-path instructions on a taken branch, and holds the front end while the multi-cycle mult/div unit is busy.
//  Sits beside the datapath, between the decode and execute stages. Its outputs feed the pipeline registers directly.
// PARAMETERS
//  REG_ADDR_W   5    register index width
//  MD_LATENCY   32   cycles the mult/div unit stays busy after issue (>=2)
//  CNT_W        6    busy counter width; must hold MD_LATENCY-1
// PORTS
//  i_clk             in   1           clock, rising edge
//  i_a_rst           in   1           asynchronous, active-high reset
//  i_id_rs/i_id_rt   in   REG_ADDR_W  source registers of the instruction in ID
//  i_id_use_rs/rt    in   1           ID instruction actually reads rs / rt
//  i_id_md_op        in   1           ID instruction is mult/div/mfhi/mflo/mthi/mtlo
//  i_ex_rd           in   REG_ADDR_W  destination of the instruction in EX
//  i_ex_reg_write    in   1           EX instruction writes the register file
//  i_ex_mem_read     in   1           EX instruction is a load
//  i_ex_branch_taken in   1           branch/jump resolved taken in EX
//  i_ex_md_start     in   1           mult/div issued from EX this cycle (1-cycle pulse)
//  i_mem_rd, i_mem_reg_write  in  REG_ADDR_W,1  destination / write flag of the MEM-stage instruction
//  i_wb_rd,  i_wb_reg_write   in  REG_ADDR_W,1  destination / write flag of the WB-stage instruction
//  o_pc_we           out  1           PC write enable
//  o_ifid_we, o_ifid_s_rst    out 1   IF/ID register controls
//  o_idex_we, o_idex_s_rst    out 1   ID/EX register controls
//  o_md_busy         out  1           mult/div unit busy (registered state)
// BEHAVIOUR
//  While i_a_rst=1: FSM=S_RUN, cnt=0, o_md_busy=0, all *_we=0, all *_s_rst=1, o_fwd_*=0.
//  Match rule: a register is "hazarded" by a stage only if the stage's reg_write=1, rd!=0, rd==src, and use_*=1.
//  load_use  = EX is a load (i_ex_mem_read) and hazards rs or rt.
//  raw_stall = without the macro: EX or MEM hazards rs/rt. With the macro: equals load_use.
//  The WB stage never stalls: the register file writes first.
//  md_stall  = o_md_busy & i_id_md_op.
//  stall     = load_use | raw_stall | md_stall.
//  Priority, evaluated combinationally each cycle:
//   1. i_ex_branch_taken: o_pc_we=1, ifid_s_rst=1, idex_s_rst=1. Any stall is ignored because the stalled instruction is squashed.
//   2. stall: o_pc_we=0, ifid_we=0, idex_s_rst=1 (bubble). IF/ID holds.
//   3. otherwise: o_pc_we=1, ifid_we=1, idex_we=1, both s_rst=0.
//  idex_we=1 whenever not in reset; s_rst overrides it inside the register.
//  Mult/div FSM (two states, S_RUN and S_MD_BUSY):
//   - S_RUN and i_ex_md_start -> S_MD_BUSY, with cnt<=MD_LATENCY-1.
//   - S_MD_BUSY: cnt decrements every cycle. When cnt==0, go to S_RUN on the next edge, so o_md_busy is high for exactly MD_LATENCY cycles.
//   - i_ex_md_start while in S_MD_BUSY cannot occur because md_stall blocks it. The bench checks this with an assertion; the RTL ignores it.
//   - A taken branch while busy does not abort the operation, which was already issued.
//   - Reset mid-operation returns to S_RUN with cnt=0 immediately (async).
// CONFIGURATION
//  `HAZARD_FWD_EN defined:
//   - Adds inputs i_ex_rs, i_ex_rt (REG_ADDR_W) and outputs o_fwd_a, o_fwd_b (2b).
//   - Selects: 00=register file, 01=from EX/MEM, 10=from MEM/WB. MEM wins over WB; rd==0 never forwards.
//   - Only load_use stalls.
//  Undefined: those ports are absent and RAW hazards in EX/MEM stall as described above.
// STRUCTURE
//  pipe_ctrl_pkg holds: state enum (S_RUN, S_MD_BUSY); FWD_RF/FWD_MEM/FWD_WB constants; REG_ZERO constant.
//  Sub-module md_busy_counter holds the FSM, counter and o_md_busy. The hazard logic stays in the top level.
// TESTING
//  1. lw r2 in EX, ID reads r2 (use_rs=1) -> one cycle with pc_we=0, ifid_we=0, idex_s_rst=1; then normal flow.
//  2. Same as 1 but i_ex_rd=0 -> no stall.
//  3. Load-use and i_ex_branch_taken in the same cycle -> pc_we=1, ifid_s_rst=1, idex_s_rst=1, no stall.
//  4. i_ex_md_start with MD_LATENCY=4, then mflo held in ID -> o_md_busy high for 4 cycles, front stalled for those 4 cycles, released on the 5th.
//  5. Reset pulsed in the 2nd busy cycle -> o_md_busy=0 asynchronously; all we=0 and s_rst=1 while reset is held.
//  6. With HAZARD_FWD_EN: add r3 in MEM, ID/EX reads r3 as rs, WB also writes r3 -> o_fwd_a=01, no stall. Without the macro -> 1-cycle stall.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// pipe_ctrl_pkg: shared types and constants for the pipeline hazard controller.
//   md_state_t : mult/div sequencer states (S_RUN, S_MD_BUSY)
//   FWD_*      : forwarding mux selects (register file, EX/MEM, MEM/WB)
//   REG_ZERO   : index of the hard-wired zero register, which is never a hazard source
package pipe_ctrl_pkg;

  typedef enum logic [0:0] {
    S_RUN     = 1'b0,
    S_MD_BUSY = 1'b1
  } md_state_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  localparam int unsigned REG_ZERO = 0;

endpackage

// File: rtl/pipe_hazard_ctrl_md_busy_counter.sv
// md_busy_counter: tracks the multi-cycle mult/div unit after an issue.
//   i_clk    in  clock, rising edge
//   i_a_rst  in  asynchronous, active-high reset
//   i_start  in  mult/div issued from EX this cycle (1-cycle pulse)
//   o_busy   out high for exactly MD_LATENCY cycles after the issue edge
// A start pulse while busy is ignored; the front end is held so it cannot occur.
module md_busy_counter
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MD_LATENCY = 32,
  parameter int unsigned CNT_W      = 6
) (
  input  logic i_clk,
  input  logic i_a_rst,
  input  logic i_start,
  output logic o_busy
);

  md_state_t        state;
  logic [CNT_W-1:0] cnt;

  // cnt is loaded with MD_LATENCY-1 and the state leaves S_MD_BUSY on the
  // edge after cnt reaches zero, giving MD_LATENCY busy cycles in total.
  always_ff @(posedge i_clk or posedge i_a_rst) begin
    if (i_a_rst) begin
      state <= S_RUN;
      cnt   <= '0;
    end else begin
      case (state)
        S_RUN: begin
          if (i_start) begin
            state <= S_MD_BUSY;
            cnt   <= CNT_W'(MD_LATENCY - 1);
          end
        end
        S_MD_BUSY: begin
          if (cnt == '0) state <= S_RUN;
          else           cnt   <= cnt - 1'b1;
        end
        default: begin
          state <= S_RUN;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign o_busy = (state == S_MD_BUSY);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush control for the IF/ID and ID/EX pipeline
// registers and the PC write enable.
//   i_clk, i_a_rst                 clock (rising), async active-high reset
//   i_id_rs/rt, i_id_use_rs/rt     ID source registers and their read flags
//   i_id_md_op                     ID instruction uses the mult/div unit
//   i_ex_rd, i_ex_reg_write,
//   i_ex_mem_read                  EX destination, write flag, load flag
//   i_ex_branch_taken              branch/jump resolved taken in EX
//   i_ex_md_start                  mult/div issued from EX (pulse)
//   i_mem_rd/reg_write,
//   i_wb_rd/reg_write              MEM and WB destinations and write flags
//   o_pc_we, o_ifid_we/s_rst,
//   o_idex_we/s_rst                pipeline register controls
//   o_md_busy                      mult/div unit busy (registered)
// Optional macro HAZARD_FWD_EN adds i_ex_rs/i_ex_rt and o_fwd_a/o_fwd_b
// forwarding selects; only load-use hazards then stall.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned MD_LATENCY = 32,
  parameter int unsigned CNT_W      = 6
) (
  input  logic                  i_clk,
  input  logic                  i_a_rst,
  input  logic [REG_ADDR_W-1:0] i_id_rs,
  input  logic [REG_ADDR_W-1:0] i_id_rt,
  input  logic                  i_id_use_rs,
  input  logic                  i_id_use_rt,
  input  logic                  i_id_md_op,
  input  logic [REG_ADDR_W-1:0] i_ex_rd,
  input  logic                  i_ex_reg_write,
  input  logic                  i_ex_mem_read,
  input  logic                  i_ex_branch_taken,
  input  logic                  i_ex_md_start,
  input  logic [REG_ADDR_W-1:0] i_mem_rd,
  input  logic                  i_mem_reg_write,
  input  logic [REG_ADDR_W-1:0] i_wb_rd,
  input  logic                  i_wb_reg_write,
`ifdef HAZARD_FWD_EN
  input  logic [REG_ADDR_W-1:0] i_ex_rs,
  input  logic [REG_ADDR_W-1:0] i_ex_rt,
  output logic [1:0]            o_fwd_a,
  output logic [1:0]            o_fwd_b,
`endif
  output logic                  o_pc_we,
  output logic                  o_ifid_we,
  output logic                  o_ifid_s_rst,
  output logic                  o_idex_we,
  output logic                  o_idex_s_rst,
  output logic                  o_md_busy
);

  localparam logic [REG_ADDR_W-1:0] ZERO_IDX = REG_ADDR_W'(REG_ZERO);

  logic ex_hz_rs, ex_hz_rt;
  logic load_use, raw_stall, md_stall, stall;

  md_busy_counter #(
    .MD_LATENCY(MD_LATENCY),
    .CNT_W     (CNT_W)
  ) u_md_busy_counter (
    .i_clk  (i_clk),
    .i_a_rst(i_a_rst),
    .i_start(i_ex_md_start),
    .o_busy (o_md_busy)
  );

  assign ex_hz_rs = i_ex_reg_write && (i_ex_rd != ZERO_IDX) && (i_ex_rd == i_id_rs) && i_id_use_rs;
  assign ex_hz_rt = i_ex_reg_write && (i_ex_rd != ZERO_IDX) && (i_ex_rd == i_id_rt) && i_id_use_rt;

  assign load_use = i_ex_mem_read && (ex_hz_rs || ex_hz_rt);
  assign md_stall = o_md_busy && i_id_md_op;

`ifdef HAZARD_FWD_EN
  // The register file writes in the first half of WB, so only EX/MEM and
  // MEM/WB results need a bypass; MEM is younger and wins.
  always_comb begin
    o_fwd_a = FWD_RF;
    o_fwd_b = FWD_RF;
    if (!i_a_rst) begin
      if (i_mem_reg_write && (i_mem_rd != ZERO_IDX) && (i_mem_rd == i_ex_rs))
        o_fwd_a = FWD_MEM;
      else if (i_wb_reg_write && (i_wb_rd != ZERO_IDX) && (i_wb_rd == i_ex_rs))
        o_fwd_a = FWD_WB;
      if (i_mem_reg_write && (i_mem_rd != ZERO_IDX) && (i_mem_rd == i_ex_rt))
        o_fwd_b = FWD_MEM;
      else if (i_wb_reg_write && (i_wb_rd != ZERO_IDX) && (i_wb_rd == i_ex_rt))
        o_fwd_b = FWD_WB;
    end
  end

  assign raw_stall = load_use;
`else
  logic mem_hz_rs, mem_hz_rt;
  // WB never stalls (register file writes first), so its tags are only
  // consumed when forwarding is built in.
  logic wb_unused;

  assign mem_hz_rs = i_mem_reg_write && (i_mem_rd != ZERO_IDX) && (i_mem_rd == i_id_rs) && i_id_use_rs;
  assign mem_hz_rt = i_mem_reg_write && (i_mem_rd != ZERO_IDX) && (i_mem_rd == i_id_rt) && i_id_use_rt;
  assign raw_stall = ex_hz_rs || ex_hz_rt || mem_hz_rs || mem_hz_rt;
  assign wb_unused = ^{i_wb_rd, i_wb_reg_write};
`endif

  assign stall = load_use || raw_stall || md_stall;

  // A taken branch squashes the stalled instruction, so it outranks stall.
  always_comb begin
    o_pc_we      = 1'b1;
    o_ifid_we    = 1'b1;
    o_ifid_s_rst = 1'b0;
    o_idex_we    = 1'b1;
    o_idex_s_rst = 1'b0;
    if (i_a_rst) begin
      o_pc_we      = 1'b0;
      o_ifid_we    = 1'b0;
      o_ifid_s_rst = 1'b1;
      o_idex_we    = 1'b0;
      o_idex_s_rst = 1'b1;
    end else if (i_ex_branch_taken) begin
      o_ifid_s_rst = 1'b1;
      o_idex_s_rst = 1'b1;
    end else if (stall) begin
      o_pc_we      = 1'b0;
      o_ifid_we    = 1'b0;
      o_idex_s_rst = 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl (MD_LATENCY=4). The driver applies one directed
// vector per cycle and queues the hand-computed outputs; a negedge monitor
// pops and compares. Expected vector order:
// {pc_we, ifid_we, ifid_s_rst, idex_we, idex_s_rst, md_busy}, plus
// {fwd_a, fwd_b} when HAZARD_FWD_EN is defined.
module tb_pipe_hazard_ctrl;

  localparam logic [5:0] NRM = 6'b110100; // normal flow
  localparam logic [5:0] STL = 6'b000110; // stall, unit idle
  localparam logic [5:0] STB = 6'b000111; // stall, unit busy
  localparam logic [5:0] BRN = 6'b111110; // flush, unit idle
  localparam logic [5:0] BRB = 6'b111111; // flush, unit busy
  localparam logic [5:0] RSV = 6'b001010; // reset values

  logic       clk, rst;
  logic [4:0] id_rs, id_rt, ex_rd, mem_rd, wb_rd, ex_rs, ex_rt;
  logic       id_use_rs, id_use_rt, id_md_op;
  logic       ex_reg_write, ex_mem_read, ex_branch_taken, ex_md_start;
  logic       mem_reg_write, wb_reg_write;
  logic       pc_we, ifid_we, ifid_s_rst, idex_we, idex_s_rst, md_busy;
  logic [1:0] fwd_a, fwd_b;

  int         checks = 0;
  int         errors = 0;
  string      nq[$];
  logic [9:0] vq[$];

  pipe_hazard_ctrl #(
    .REG_ADDR_W(5),
    .MD_LATENCY(4),
    .CNT_W     (3)
  ) dut (
    .i_clk            (clk),
    .i_a_rst          (rst),
    .i_id_rs          (id_rs),
    .i_id_rt          (id_rt),
    .i_id_use_rs      (id_use_rs),
    .i_id_use_rt      (id_use_rt),
    .i_id_md_op       (id_md_op),
    .i_ex_rd          (ex_rd),
    .i_ex_reg_write   (ex_reg_write),
    .i_ex_mem_read    (ex_mem_read),
    .i_ex_branch_taken(ex_branch_taken),
    .i_ex_md_start    (ex_md_start),
    .i_mem_rd         (mem_rd),
    .i_mem_reg_write  (mem_reg_write),
    .i_wb_rd          (wb_rd),
    .i_wb_reg_write   (wb_reg_write),
`ifdef HAZARD_FWD_EN
    .i_ex_rs          (ex_rs),
    .i_ex_rt          (ex_rt),
    .o_fwd_a          (fwd_a),
    .o_fwd_b          (fwd_b),
`endif
    .o_pc_we          (pc_we),
    .o_ifid_we        (ifid_we),
    .o_ifid_s_rst     (ifid_s_rst),
    .o_idex_we        (idex_we),
    .o_idex_s_rst     (idex_s_rst),
    .o_md_busy        (md_busy)
  );

`ifndef HAZARD_FWD_EN
  assign fwd_a = 2'b00;
  assign fwd_b = 2'b00;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The front end holds while busy, so a second issue must never be seen.
  always @(posedge clk) begin
    if (!rst && ex_md_start) begin
      assert (!md_busy) else $error("FAIL md_start_while_busy: busy=%b required 0", md_busy);
    end
  end

  always @(negedge clk) begin
    logic [9:0] e;
    logic [9:0] a;
    string      n;
    while (vq.size() != 0) begin
      e = vq.pop_front();
      n = nq.pop_front();
      a = {fwd_a, fwd_b, pc_we, ifid_we, ifid_s_rst, idex_we, idex_s_rst, md_busy};
      checks++;
`ifdef HAZARD_FWD_EN
      if (a !== e) begin
`else
      if (a[5:0] !== e[5:0]) begin
`endif
        errors++;
        $display("FAIL %s: got %b required %b", n, a, e);
      end
    end
  end

  task automatic clr();
    id_rs = '0; id_rt = '0; ex_rd = '0; mem_rd = '0; wb_rd = '0;
    ex_rs = '0; ex_rt = '0;
    id_use_rs = 1'b0; id_use_rt = 1'b0; id_md_op = 1'b0;
    ex_reg_write = 1'b0; ex_mem_read = 1'b0; ex_branch_taken = 1'b0;
    ex_md_start = 1'b0; mem_reg_write = 1'b0; wb_reg_write = 1'b0;
  endtask

  // Inputs are already applied; queue the expectation and advance one cycle.
  task automatic cyc(input string nm, input logic [5:0] v, input logic [3:0] f);
    nq.push_back(nm);
    vq.push_back({f, v});
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    clr();
    @(posedge clk);
    #1;
    cyc("reset", RSV, 4'b0000);
    rst = 1'b0;
    cyc("idle", NRM, 4'b0000);

    // load-use on rs, then normal flow
    ex_rd = 5'd2; ex_reg_write = 1'b1; ex_mem_read = 1'b1;
    id_rs = 5'd2; id_use_rs = 1'b1;
    cyc("load_use_rs", STL, 4'b0000);
    clr();
    cyc("after_load_use", NRM, 4'b0000);

    // same match but ID does not read rs
    ex_rd = 5'd2; ex_reg_write = 1'b1; ex_mem_read = 1'b1; id_rs = 5'd2;
    cyc("no_use_flag", NRM, 4'b0000);

    // load-use on rt
    clr();
    ex_rd = 5'd7; ex_reg_write = 1'b1; ex_mem_read = 1'b1;
    id_rt = 5'd7; id_use_rt = 1'b1;
    cyc("load_use_rt", STL, 4'b0000);

    // load into r0 is never a hazard
    clr();
    ex_rd = 5'd0; ex_reg_write = 1'b1; ex_mem_read = 1'b1;
    id_rs = 5'd0; id_use_rs = 1'b1;
    cyc("load_r0", NRM, 4'b0000);

    // load-use together with a taken branch: squash wins
    clr();
    ex_rd = 5'd2; ex_reg_write = 1'b1; ex_mem_read = 1'b1;
    id_rs = 5'd2; id_use_rs = 1'b1; ex_branch_taken = 1'b1;
    cyc("load_use_branch", BRN, 4'b0000);

    // non-load RAW in EX
    clr();
    ex_rd = 5'd5; ex_reg_write = 1'b1; id_rt = 5'd5; id_use_rt = 1'b1;
`ifdef HAZARD_FWD_EN
    cyc("raw_ex", NRM, 4'b0000);
`else
    cyc("raw_ex", STL, 4'b0000);
`endif

    // r3 in MEM and WB, ID and EX read r3 as rs: MEM forward wins
    clr();
    mem_rd = 5'd3; mem_reg_write = 1'b1; wb_rd = 5'd3; wb_reg_write = 1'b1;
    id_rs = 5'd3; id_use_rs = 1'b1; ex_rs = 5'd3;
`ifdef HAZARD_FWD_EN
    cyc("raw_mem", NRM, 4'b0100);
`else
    cyc("raw_mem", STL, 4'b0000);
`endif

    // WB-only producer never stalls; rt forwards from MEM/WB
    clr();
    wb_rd = 5'd4; wb_reg_write = 1'b1; id_rt = 5'd4; id_use_rt = 1'b1; ex_rt = 5'd4;
    cyc("raw_wb", NRM, 4'b0010);

    // MEM writes r0: no forward, no stall
    clr();
    mem_rd = 5'd0; mem_reg_write = 1'b1; id_rs = 5'd0; id_use_rs = 1'b1; ex_rs = 5'd0;
    cyc("mem_r0", NRM, 4'b0000);

    // mult/div issue, mflo held in ID for 4 busy cycles; branch mid-way
    clr();
    ex_md_start = 1'b1;
    cyc("md_issue", NRM, 4'b0000);
    ex_md_start = 1'b0; id_md_op = 1'b1;
    cyc("md_busy1", STB, 4'b0000);
    ex_branch_taken = 1'b1;
    cyc("md_busy2_branch", BRB, 4'b0000);
    ex_branch_taken = 1'b0;
    cyc("md_busy3", STB, 4'b0000);
    cyc("md_busy4", STB, 4'b0000);
    cyc("md_release", NRM, 4'b0000);

    // reset asserted during the 2nd busy cycle
    clr();
    ex_md_start = 1'b1;
    cyc("md_issue2", NRM, 4'b0000);
    ex_md_start = 1'b0; id_md_op = 1'b1;
    cyc("md2_busy1", STB, 4'b0000);
    rst = 1'b1;
    cyc("rst_mid_busy", RSV, 4'b0000);
    cyc("rst_hold", RSV, 4'b0000);
    rst = 1'b0;
    cyc("after_rst", NRM, 4'b0000);

    for (int i = 0; i < 5 && vq.size() != 0; i++) @(negedge clk);
    #1;
    if (vq.size() != 0) begin
      errors++;
      $display("FAIL drain: pending=%0d required 0", vq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
